// File: rtl/fifo_spi_readout_pkg.sv
// Shared constants and types for the TDC FIFO SPI read side.
package fifo_spi_readout_pkg;

  // Frame layout: status byte followed by the 32-bit FIFO word, MSB first.
  localparam int unsigned STAT_W  = 8;
  localparam int unsigned FRAME_W = 40;

  // Status byte bit positions.
  localparam int unsigned ST_VALID  = 7;
  localparam int unsigned ST_OVF    = 6;
  localparam int unsigned ST_CNT_HI = 5;
  localparam int unsigned ST_CNT_LO = 0;

  // Width of the completed-valid-frame counter carried in the status byte.
  localparam int unsigned CNT_W = ST_CNT_HI - ST_CNT_LO + 1;

  typedef enum logic [1:0] {
    StIdle,
    StArm,
    StShift,
    StDone
  } state_e;

endpackage

// File: rtl/fifo_spi_readout_spi_in_sync.sv
// Multi-stage synchronizer for one asynchronous SPI pin, with registered
// single-cycle rise/fall pulses derived from the synchronized level.
module spi_in_sync #(
  parameter int unsigned Stages   = 2,     // at least 2
  parameter logic        ResetVal = 1'b0   // idle level of the pin
) (
  input  logic clk_i,
  input  logic rst_i,
  input  logic d_i,
  output logic level_o,
  output logic rise_o,
  output logic fall_o
);

  logic [Stages-1:0] sync_q, sync_d;
  logic              prev_q, prev_d;
  logic              rise_q, rise_d;
  logic              fall_q, fall_d;

  // Shift the pin through the chain and compare the last stage with its previous value.
  always_comb begin
    sync_d = {sync_q[Stages-2:0], d_i};
    prev_d = sync_q[Stages-1];
    rise_d = sync_q[Stages-1] & ~prev_q;
    fall_d = ~sync_q[Stages-1] & prev_q;
  end

  // Synchronizer, edge-detect and pulse registers.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      sync_q <= {Stages{ResetVal}};
      prev_q <= ResetVal;
      rise_q <= 1'b0;
      fall_q <= 1'b0;
    end else begin
      sync_q <= sync_d;
      prev_q <= prev_d;
      rise_q <= rise_d;
      fall_q <= fall_d;
    end
  end

  assign level_o = sync_q[Stages-1];
  assign rise_o  = rise_q;
  assign fall_o  = fall_q;

endmodule

// File: rtl/fifo_spi_readout.sv
// Read side of the TDC measurement FIFO: prefetches one word into a staging
// register and serves it to an SPI master (mode 0) as a 40-bit frame made of a
// status byte and the data word, one word per chip-select frame.
module fifo_spi_readout #(
  parameter int unsigned DATA_W      = 32,
  parameter int unsigned STAT_W      = 8,
  parameter int unsigned SYNC_STAGES = 2
) (
  input  logic              iClk,
  input  logic              iRst,
  input  logic              iEmpty,
  input  logic [DATA_W-1:0] iData,
  input  logic              iOvf,
  input  logic              iSclk,
  input  logic              iCsN,
  output logic              oReadEN,
  output logic              oMiso,
  output logic              oMisoOe,
  output logic              oFrameDone,
  output logic              oBusy
);

  import fifo_spi_readout_pkg::*;

  localparam int unsigned FrameW = STAT_W + DATA_W;
  localparam int unsigned BitW   = $clog2(FrameW);
  localparam logic [BitW-1:0] LastBit = BitW'(FrameW - 1);

  // Synchronized SPI inputs.
  logic sclk_level, sclk_rise, sclk_fall;
  logic cs_level, cs_rise, cs_fall;
  logic unused_sclk;

  spi_in_sync #(
    .Stages  (SYNC_STAGES),
    .ResetVal(1'b0)
  ) u_sclk_sync (
    .clk_i  (iClk),
    .rst_i  (iRst),
    .d_i    (iSclk),
    .level_o(sclk_level),
    .rise_o (sclk_rise),
    .fall_o (sclk_fall)
  );

  spi_in_sync #(
    .Stages  (SYNC_STAGES),
    .ResetVal(1'b1)
  ) u_cs_sync (
    .clk_i  (iClk),
    .rst_i  (iRst),
    .d_i    (iCsN),
    .level_o(cs_level),
    .rise_o (cs_rise),
    .fall_o (cs_fall)
  );

  // Mode 0 only needs the falling edge of SCLK.
  assign unused_sclk = sclk_level ^ sclk_rise;

  // Staging register state.
  logic              run_q, run_d;
  logic              pend_q, pend_d;
  logic              staged_q, staged_d;
  logic [DATA_W-1:0] word_q, word_d;
  logic              retire;

  // Frame FSM state.
  state_e            state_q, state_d;
  logic [FrameW-1:0] shift_q, shift_d;
  logic [BitW-1:0]   bit_cnt_q, bit_cnt_d;
  logic              valid_q, valid_d;
  logic [CNT_W-1:0]  frame_cnt_q, frame_cnt_d;
  logic              done_q, done_d;
  logic              busy_q, busy_d;
  logic              oe_q, oe_d;
  logic [STAT_W-1:0] status;
  logic [DATA_W-1:0] data_sel;

  // run_q keeps the read strobe quiet while reset is held and for one cycle after.
  assign oReadEN = run_q & ~staged_q & ~pend_q & ~iEmpty;

  // Prefetch: a read issued this cycle returns data next cycle, which fills the stage.
  always_comb begin
    run_d    = 1'b1;
    pend_d   = oReadEN;
    staged_d = staged_q;
    word_d   = word_q;
    if (pend_q) begin
      word_d   = iData;
      staged_d = 1'b1;
    end else if (retire) begin
      staged_d = 1'b0;
    end
  end

  // Staging registers.
  always_ff @(posedge iClk or posedge iRst) begin
    if (iRst) begin
      run_q    <= 1'b0;
      pend_q   <= 1'b0;
      staged_q <= 1'b0;
      word_q   <= '0;
    end else begin
      run_q    <= run_d;
      pend_q   <= pend_d;
      staged_q <= staged_d;
      word_q   <= word_d;
    end
  end

  // Frame FSM next state: load in ARM, shift on SCLK falls, finish or abort on CS rise.
  always_comb begin
    state_d     = state_q;
    shift_d     = shift_q;
    bit_cnt_d   = bit_cnt_q;
    valid_d     = valid_q;
    frame_cnt_d = frame_cnt_q;
    done_d      = 1'b0;
    retire      = 1'b0;

    status            = '0;
    status[ST_VALID]  = staged_q;
    status[ST_OVF]    = iOvf;
    status[ST_CNT_HI:ST_CNT_LO] = frame_cnt_q;
    data_sel          = staged_q ? word_q : {DATA_W{1'b0}};

    unique case (state_q)
      StIdle: begin
        if (cs_fall) begin
          state_d = StArm;
        end
      end
      StArm: begin
        // Snapshot is taken here; a capture landing later does not change this frame.
        shift_d   = {status, data_sel};
        valid_d   = staged_q;
        bit_cnt_d = '0;
        if (cs_rise) begin
          shift_d = '0;
          state_d = StIdle;
        end else begin
          state_d = StShift;
        end
      end
      StShift: begin
        if (cs_rise) begin
          shift_d = '0;
          if (bit_cnt_q == LastBit) begin
            state_d = StDone;
            done_d  = 1'b1;
          end else begin
            state_d = StIdle;
          end
        end else if (sclk_fall) begin
          // Zero fill makes MISO read 0 once all bits are out.
          shift_d = {shift_q[FrameW-2:0], 1'b0};
          if (bit_cnt_q != LastBit) begin
            bit_cnt_d = bit_cnt_q + 1'b1;
          end
        end
      end
      StDone: begin
        state_d = StIdle;
        if (valid_q) begin
          retire      = 1'b1;
          frame_cnt_d = frame_cnt_q + 1'b1;
        end
      end
      default: begin
        state_d = StIdle;
      end
    endcase

    busy_d = (state_d != StIdle);
    oe_d   = ~cs_level;
  end

  // Frame FSM and registered outputs.
  always_ff @(posedge iClk or posedge iRst) begin
    if (iRst) begin
      state_q     <= StIdle;
      shift_q     <= '0;
      bit_cnt_q   <= '0;
      valid_q     <= 1'b0;
      frame_cnt_q <= '0;
      done_q      <= 1'b0;
      busy_q      <= 1'b0;
      oe_q        <= 1'b0;
    end else begin
      state_q     <= state_d;
      shift_q     <= shift_d;
      bit_cnt_q   <= bit_cnt_d;
      valid_q     <= valid_d;
      frame_cnt_q <= frame_cnt_d;
      done_q      <= done_d;
      busy_q      <= busy_d;
      oe_q        <= oe_d;
    end
  end

  assign oMiso      = shift_q[FrameW-1];
  assign oMisoOe    = oe_q;
  assign oFrameDone = done_q;
  assign oBusy      = busy_q;

endmodule
